ram_arbiter: RTL

Shares the single RAM port (address bus, bidirectional 64-bit data bus, cs/we/oe strobes) between two requesters: port 0 for CPU instruction fetch and ld/sd traffic, port 1 for the program loader/debug port. It sits between the CPU core and the RAM. It accepts one request at a time through a req/ack handshake, arbitrates ties round-robin, and sequences each access through a fixed-latency RAM cycle.

---
 rtl/ram_arbiter_pkg.sv | 34 +++
 rtl/ram_arbiter_rr_pick2.sv | 36 +++
 rtl/ram_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Requester identities
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   // RAM latency bounds and the width of the latency counter
   localparam int RAM_LAT_MIN = 1;
   localparam int RAM_LAT_MAX = 15;
   localparam int CNT_W       = 4;

   // Counter preload for a given latency; out-of-range values are clamped
   // so the counter can never wrap into a very long access.
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      int v;
      if (lat < RAM_LAT_MIN) begin
         v = RAM_LAT_MIN;
      end else if (lat > RAM_LAT_MAX) begin
         v = RAM_LAT_MAX;
      end else begin
         v = lat;
      end
      return CNT_W'(v - 1);
   endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_pick2
   import ram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       valid,
   output logic       gnt_id
);

   // Select the winner from the current request pattern
   always_comb begin
      valid  = 1'b0;
      gnt_id = last_gnt;
      case (req)
         2'b01: begin
            valid  = 1'b1;
            gnt_id = PORT_CPU;
         end
         2'b10: begin
            valid  = 1'b1;
            gnt_id = PORT_LDR;
         end
         2'b11: begin
            valid  = 1'b1;
            gnt_id = ~last_gnt;
         end
         default: begin
            valid  = 1'b0;
            gnt_id = last_gnt;
         end
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one fixed-latency RAM port between the CPU (port 0) and the
// loader/debug port (port 1). One transaction at a time: grant in IDLE,
// hold the strobes for RAM_LAT cycles in ACCESS, pulse ack in DONE.
// All outputs except the tristate data bus come straight from flops.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int RAM_LAT = 1,
   parameter int ADDR_W  = 64
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [63:0]       wdata0,
   input  logic [63:0]       wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [63:0]       rdata,
   output logic              busy,
   output logic              gnt_id,
   output logic [ADDR_W-1:0] bus_addr,
   inout  wire  [63:0]       bus_data,
   output logic              ram_cs,
   output logic              ram_we,
   output logic              ram_oe
);

   localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(RAM_LAT);

   // Registered state
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [63:0]        r_wdata;
   logic               r_last_gnt;
   logic               r_gnt_id;
   logic [63:0]        r_rdata;
   logic               r_ack0;
   logic               r_ack1;
   logic               r_busy;
   logic               r_ram_cs;
   logic               r_ram_we;
   logic               r_ram_oe;
   logic [ADDR_W-1:0]  r_bus_addr;

   // Next-state values
   state_t             w_state_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_we_next;
   logic [ADDR_W-1:0]  w_addr_next;
   logic [63:0]        w_wdata_next;
   logic               w_last_gnt_next;
   logic               w_gnt_id_next;
   logic [63:0]        w_rdata_next;
   logic               w_acc_next;
   logic               w_ack0_next;
   logic               w_ack1_next;
   logic               w_busy_next;
   logic               w_ram_cs_next;
   logic               w_ram_we_next;
   logic               w_ram_oe_next;
   logic [ADDR_W-1:0]  w_bus_addr_next;

   logic               w_pick_valid;
   logic               w_pick_id;

   rr_pick2 u_pick (
      .req      ({req1, req0}),
      .last_gnt (r_last_gnt),
      .valid    (w_pick_valid),
      .gnt_id   (w_pick_id)
   );

   // Sequencer next state: grant and latch in IDLE, count in ACCESS,
   // capture read data on the last ACCESS cycle
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_we_next       = r_we;
      w_addr_next     = r_addr;
      w_wdata_next    = r_wdata;
      w_gnt_id_next   = r_gnt_id;
      w_last_gnt_next = r_last_gnt;
      w_rdata_next    = r_rdata;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_state_next    = ACCESS;
               w_gnt_id_next   = w_pick_id;
               w_last_gnt_next = w_pick_id;
               w_cnt_next      = LAT_LOAD;
               if (w_pick_id == PORT_LDR) begin
                  w_we_next    = we1;
                  w_addr_next  = addr1;
                  w_wdata_next = wdata1;
               end else begin
                  w_we_next    = we0;
                  w_addr_next  = addr0;
                  w_wdata_next = wdata0;
               end
            end else begin
               w_state_next = IDLE;
            end
         end
         ACCESS: begin
            if (r_cnt == {CNT_W{1'b0}}) begin
               w_state_next = DONE;
               if (!r_we) begin
                  w_rdata_next = bus_data;
               end else begin
                  w_rdata_next = r_rdata;
               end
            end else begin
               w_cnt_next = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so
   // the strobes and ack leave flops directly
   always_comb begin
      w_acc_next    = (w_state_next == ACCESS);
      w_ram_cs_next = w_acc_next;
      w_ram_we_next = w_acc_next & w_we_next;
      w_ram_oe_next = w_acc_next & ~w_we_next;
      w_busy_next   = (w_state_next == ACCESS) || (w_state_next == DONE);
      if (w_acc_next) begin
         w_bus_addr_next = w_addr_next;
      end else begin
         w_bus_addr_next = {ADDR_W{1'b0}};
      end
      if (w_state_next == DONE) begin
         w_ack0_next = (w_gnt_id_next == PORT_CPU);
         w_ack1_next = (w_gnt_id_next == PORT_LDR);
      end else begin
         w_ack0_next = 1'b0;
         w_ack1_next = 1'b0;
      end
   end

   // State and output registers; reset aborts any access immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= {CNT_W{1'b0}};
         r_we       <= 1'b0;
         r_addr     <= {ADDR_W{1'b0}};
         r_wdata    <= 64'd0;
         r_last_gnt <= 1'b1;
         r_gnt_id   <= 1'b0;
         r_rdata    <= 64'd0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_busy     <= 1'b0;
         r_ram_cs   <= 1'b0;
         r_ram_we   <= 1'b0;
         r_ram_oe   <= 1'b0;
         r_bus_addr <= {ADDR_W{1'b0}};
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_we       <= w_we_next;
         r_addr     <= w_addr_next;
         r_wdata    <= w_wdata_next;
         r_last_gnt <= w_last_gnt_next;
         r_gnt_id   <= w_gnt_id_next;
         r_rdata    <= w_rdata_next;
         r_ack0     <= w_ack0_next;
         r_ack1     <= w_ack1_next;
         r_busy     <= w_busy_next;
         r_ram_cs   <= w_ram_cs_next;
         r_ram_we   <= w_ram_we_next;
         r_ram_oe   <= w_ram_oe_next;
         r_bus_addr <= w_bus_addr_next;
      end
   end

   // Data bus is driven only during a write strobe
   assign bus_data = r_ram_we ? r_wdata : {64{1'bz}};

   assign ack0     = r_ack0;
   assign ack1     = r_ack1;
   assign rdata    = r_rdata;
   assign busy     = r_busy;
   assign gnt_id   = r_gnt_id;
   assign bus_addr = r_bus_addr;
   assign ram_cs   = r_ram_cs;
   assign ram_we   = r_ram_we;
   assign ram_oe   = r_ram_oe;

endmodule
